// File: rtl/scan_chain_ctrl.sv
// Scan tester: shifts pattern in MSB-first, captures CAPTURE_CYCLES, shifts response out; done 2N+C edges after start.
// No backpressure: start is taken only in IDLE (busy=0) and is ignored otherwise.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN      = 8,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic [CHAIN_LEN-1:0] mask,
  input  logic                 scan_out,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 pass
);

  localparam int MAXL = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
  localparam int CW   = $clog2(MAXL) + 1;
  localparam logic [CW-1:0] SHIFT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CAP_LAST   = CW'(CAPTURE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [CHAIN_LEN-1:0] sr, sr_nxt;
  logic [CHAIN_LEN-1:0] exp_r, exp_nxt;
  logic [CHAIN_LEN-1:0] mask_r, mask_nxt;
  logic [CHAIN_LEN-1:0] resp_nxt;
  logic [CHAIN_LEN-1:0] sr_sampled;
  logic                 scan_en_nxt, scan_in_nxt, busy_nxt, done_nxt, pass_nxt;

  // One register serves both directions: pattern drains out the top, response fills from the bottom.
  assign sr_sampled = {sr[CHAIN_LEN-2:0], scan_out};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      exp_r    <= '0;
      mask_r   <= '0;
      scan_en  <= 1'b0;
      scan_in  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      response <= '0;
      pass     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sr       <= sr_nxt;
      exp_r    <= exp_nxt;
      mask_r   <= mask_nxt;
      scan_en  <= scan_en_nxt;
      scan_in  <= scan_in_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      response <= resp_nxt;
      pass     <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    sr_nxt      = sr;
    exp_nxt     = exp_r;
    mask_nxt    = mask_r;
    scan_en_nxt = scan_en;
    scan_in_nxt = scan_in;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    resp_nxt    = response;
    pass_nxt    = pass;
    case (state)
      IDLE: begin
        if (start) begin
          sr_nxt      = pattern;
          exp_nxt     = expected;
          mask_nxt    = mask;
          scan_en_nxt = 1'b1;
          scan_in_nxt = pattern[CHAIN_LEN-1];
          busy_nxt    = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = SHIFT_IN;
        end
      end
      SHIFT_IN: begin
        scan_in_nxt = sr[CHAIN_LEN-2];
        sr_nxt      = {sr[CHAIN_LEN-2:0], 1'b0};
        if (cnt == SHIFT_LAST) begin
          scan_en_nxt = 1'b0;
          scan_in_nxt = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = CAPTURE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      CAPTURE: begin
        if (cnt == CAP_LAST) begin
          scan_en_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = SHIFT_OUT;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      SHIFT_OUT: begin
        sr_nxt = sr_sampled;
        if (cnt == SHIFT_LAST) begin
          resp_nxt    = sr_sampled;
          pass_nxt    = ~|((sr_sampled ^ exp_r) & mask_r);
          scan_en_nxt = 1'b0;
          busy_nxt    = 1'b0;
          done_nxt    = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
